// File: rtl/vga_timing_pkg.sv
// 800x600@56Hz link timing shared by the VGA transmitter and receiver,
// plus receiver state encoding and small helpers.
package vga_timing_pkg;

   localparam int unsigned VGA_H_TOTAL   = 1024;
   localparam int unsigned VGA_H_START   = 128;
   localparam int unsigned VGA_H_VISIBLE = 800;
   localparam int unsigned VGA_V_TOTAL   = 625;
   localparam int unsigned VGA_V_START   = 22;
   localparam int unsigned VGA_V_VISIBLE = 600;
   localparam bit          VGA_SYNC_POL  = 1'b1;

   typedef enum logic [1:0] {
      SEARCH,
      SYNC1,
      LOCKED
   } rx_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == '1) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Samples one sync line and flags its deassert edge (active -> inactive)
// using the configured sync polarity.
module vga_sync_edge #(
   parameter bit SYNC_POL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sync_in,
   output logic deassert
);

   logic sync_q;
   logic sync_qq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= ~SYNC_POL;
         sync_qq <= ~SYNC_POL;
      end else begin
         sync_q  <= sync_in;
         sync_qq <= sync_q;
      end
   end

   assign deassert = (sync_q != SYNC_POL) && (sync_qq == SYNC_POL);

endmodule

// File: rtl/vga_timing_receiver.sv
// Receive side of the VGA link: recovers pixel coordinate/colour, checks
// line and frame periods, and tracks lock over consecutive good frames.
module vga_timing_receiver
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_TOTAL   = VGA_H_TOTAL,
   parameter int unsigned H_START   = VGA_H_START,
   parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
   parameter int unsigned V_TOTAL   = VGA_V_TOTAL,
   parameter int unsigned V_START   = VGA_V_START,
   parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
   parameter bit          SYNC_POL  = VGA_SYNC_POL
) (
   input  logic        clk_36MHz,
   input  logic        reset,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [2:0]  rgb,
   output logic [9:0]  rx_x,
   output logic [9:0]  rx_y,
   output logic [2:0]  rx_rgb,
   output logic        rx_valid,
   output logic        frame_start,
   output logic        locked,
   output logic [7:0]  line_err_count,
   output logic [15:0] frame_count
);

   localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
   localparam logic [10:0] H_FIRST   = 11'(H_START);
   localparam logic [10:0] H_LAST    = 11'(H_START + H_VISIBLE);
   localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
   localparam logic [9:0]  V_FIRST   = 10'(V_START);
   localparam logic [9:0]  V_LAST    = 10'(V_START + V_VISIBLE);

   logic        hs_edge;
   logic        vs_edge;
   logic [2:0]  rgb_q;
   logic [10:0] h_cnt;
   logic [9:0]  v_cnt;
   logic [10:0] h_now;
   logic [9:0]  v_now;
   logic [11:0] line_len;
   logic [10:0] frame_len;
   logic        line_err;
   logic        frame_err;
   logic        visible;
   logic        h_armed;
   logic        frame_bad;
   rx_state_t   state;

   vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hs_edge (
      .clk      (clk_36MHz),
      .rst_n    (reset),
      .sync_in  (hsync),
      .deassert (hs_edge)
   );

   vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vs_edge (
      .clk      (clk_36MHz),
      .rst_n    (reset),
      .sync_in  (vsync),
      .deassert (vs_edge)
   );

   // Counts are evaluated for the current stage-1 sample so the output
   // registers land two clocks after the pins rather than three.
   always_comb begin
      h_now     = hs_edge ? '0 : ((h_cnt == '1) ? h_cnt : h_cnt + 11'd1);
      v_now     = vs_edge ? '0 : ((hs_edge && v_cnt != '1) ? v_cnt + 10'd1 : v_cnt);
      line_len  = {1'b0, h_cnt} + 12'd1;
      frame_len = {1'b0, v_cnt} + {10'd0, hs_edge};
      line_err  = hs_edge && h_armed && (line_len != H_TOTAL_W);
      frame_err = vs_edge && (frame_len != V_TOTAL_W);
      visible   = (h_now >= H_FIRST) && (h_now < H_LAST) &&
                  (v_now >= V_FIRST) && (v_now < V_LAST);
   end

   always_ff @(posedge clk_36MHz or negedge reset) begin
      if (!reset) begin
         rgb_q          <= '0;
         h_cnt          <= '0;
         v_cnt          <= '0;
         h_armed        <= 1'b0;
         frame_bad      <= 1'b0;
         state          <= SEARCH;
         locked         <= 1'b0;
         rx_x           <= '0;
         rx_y           <= '0;
         rx_rgb         <= '0;
         rx_valid       <= 1'b0;
         frame_start    <= 1'b0;
         line_err_count <= '0;
         frame_count    <= '0;
      end else begin
         rgb_q       <= rgb;
         h_cnt       <= h_now;
         v_cnt       <= v_now;
         rx_valid    <= visible;
         rx_x        <= visible ? 10'(h_now - H_FIRST) : '0;
         rx_y        <= visible ? (v_now - V_FIRST) : '0;
         rx_rgb      <= visible ? rgb_q : '0;
         frame_start <= vs_edge;

         if (line_err && state != SEARCH)
            line_err_count <= sat_inc8(line_err_count);
         if (vs_edge && state != SEARCH)
            frame_count <= frame_count + 16'd1;

         if (vs_edge)
            frame_bad <= 1'b0;
         else if (line_err)
            frame_bad <= 1'b1;

         // Losing lock re-enters SEARCH, whose first line edge is never judged.
         if (state == LOCKED && (line_err || frame_err))
            h_armed <= 1'b0;
         else if (hs_edge)
            h_armed <= 1'b1;

         case (state)
            SEARCH: begin
               if (vs_edge)
                  state <= SYNC1;
            end
            SYNC1: begin
               if (vs_edge && !(frame_bad || line_err || frame_err)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
               end
            end
            LOCKED: begin
               if (line_err || frame_err) begin
                  state  <= SEARCH;
                  locked <= 1'b0;
               end
            end
            default: begin
               state  <= SEARCH;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver using a shrunken raster
// (16 clocks x 10 lines, 8x6 visible) so that many frames fit in a short run.
module tb_vga_timing_receiver;

   localparam int unsigned HT = 16;
   localparam int unsigned HS = 4;
   localparam int unsigned HV = 8;
   localparam int unsigned VT = 10;
   localparam int unsigned VS = 2;
   localparam int unsigned VV = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        hsync = 1'b0;
   logic        vsync = 1'b0;
   logic [2:0]  rgb = '0;
   logic [9:0]  rx_x;
   logic [9:0]  rx_y;
   logic [2:0]  rx_rgb;
   logic        rx_valid;
   logic        frame_start;
   logic        locked;
   logic [7:0]  line_err_count;
   logic [15:0] frame_count;

   vga_timing_receiver #(
      .H_TOTAL   (HT),
      .H_START   (HS),
      .H_VISIBLE (HV),
      .V_TOTAL   (VT),
      .V_START   (VS),
      .V_VISIBLE (VV),
      .SYNC_POL  (1'b1)
   ) dut (
      .clk_36MHz      (clk),
      .reset          (reset),
      .hsync          (hsync),
      .vsync          (vsync),
      .rgb            (rgb),
      .rx_x           (rx_x),
      .rx_y           (rx_y),
      .rx_rgb         (rx_rgb),
      .rx_valid       (rx_valid),
      .frame_start    (frame_start),
      .locked         (locked),
      .line_err_count (line_err_count),
      .frame_count    (frame_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Output monitor: counts visible pixels and frame pulses, records
   // the first/last visible pixel and the frame_start count when lock first rises.
   int         valid_total = 0;
   int         fs_cnt      = 0;
   int         lock_fs     = -1;
   logic       seen_valid  = 1'b0;
   logic       locked_d    = 1'b0;
   logic [9:0] first_x = '0, first_y = '0, last_x = '0, last_y = '0;
   logic [2:0] first_rgb = '0, last_rgb = '0;

   always @(negedge clk) begin
      if (frame_start)
         fs_cnt <= fs_cnt + 1;
      if (rx_valid) begin
         valid_total <= valid_total + 1;
         if (!seen_valid) begin
            seen_valid <= 1'b1;
            first_x    <= rx_x;
            first_y    <= rx_y;
            first_rgb  <= rx_rgb;
         end
         last_x   <= rx_x;
         last_y   <= rx_y;
         last_rgb <= rx_rgb;
      end
      if (locked && !locked_d && lock_fs < 0)
         lock_fs <= fs_cnt + (frame_start ? 1 : 0);
      locked_d <= locked;
   end

   function automatic logic [2:0] pix(input int c);
      return (c >= int'(HS) && c < int'(HS + HV)) ? 3'b101 : 3'b010;
   endfunction

   task automatic drive_cycle(input logic h, input logic v, input logic [2:0] c);
      @(posedge clk);
      #1;
      hsync = h;
      vsync = v;
      rgb   = c;
   endtask

   task automatic drive_line(input int len, input logic v_act);
      for (int c = 0; c < len; c++)
         drive_cycle(c >= len - 2, v_act, pix(c));
   endtask

   task automatic drive_frame(input int lines);
      for (int l = 0; l < lines; l++)
         drive_line(HT, l == lines - 1);
   endtask

   initial begin
      // Reset held while inputs toggle
      for (int i = 0; i < 12; i++)
         drive_cycle((i % 2) == 1, (i % 3) == 0, 3'(i));
      @(negedge clk);
      check_val("rst rx_x", rx_x, 0);
      check_val("rst rx_y", rx_y, 0);
      check_val("rst rx_rgb", rx_rgb, 0);
      check_val("rst rx_valid", rx_valid, 0);
      check_val("rst frame_start", frame_start, 0);
      check_val("rst locked", locked, 0);
      check_val("rst line_err_count", line_err_count, 0);
      check_val("rst frame_count", frame_count, 0);

      drive_cycle(1'b0, 1'b0, 3'b000);
      reset = 1'b1;
      drive_line(HT, 1'b1);

      // Three clean frames
      drive_frame(VT);
      check_val("f1 locked", locked, 0);
      check_val("f1 valid count", valid_total, HV * VV);
      check_val("first rx_x", first_x, 0);
      check_val("first rx_y", first_y, 0);
      check_val("first rx_rgb", first_rgb, 3'b101);
      check_val("last rx_x", last_x, HV - 1);
      check_val("last rx_y", last_y, VV - 1);
      check_val("last rx_rgb", last_rgb, 3'b101);
      drive_frame(VT);
      check_val("f2 locked", locked, 1);
      drive_frame(VT);
      check_val("lock at 2nd frame_start", lock_fs, 2);
      check_val("f3 valid total", valid_total, 3 * HV * VV);
      check_val("f3 frame_count", frame_count, 2);
      check_val("f3 line_err_count", line_err_count, 0);

      // Frame 4: line 4 one clock short
      for (int l = 0; l < 4; l++)
         drive_line(HT, 1'b0);
      drive_line(HT - 1, 1'b0);
      drive_cycle(1'b0, 1'b0, pix(0));
      drive_cycle(1'b0, 1'b0, pix(1));
      @(negedge clk);
      check_val("short pre locked", locked, 1);
      check_val("short pre errcnt", line_err_count, 0);
      drive_cycle(1'b0, 1'b0, pix(2));
      @(negedge clk);
      check_val("short post locked", locked, 0);
      check_val("short post errcnt", line_err_count, 1);
      for (int c = 3; c < int'(HT); c++)
         drive_cycle(c >= int'(HT) - 2, 1'b0, pix(c));
      for (int l = 6; l < int'(VT); l++)
         drive_line(HT, l == int'(VT) - 1);

      // Frames 5-7 clean: relock
      drive_frame(VT);
      drive_frame(VT);
      drive_frame(VT);
      check_val("relock locked", locked, 1);
      check_val("relock frame_count", frame_count, 5);
      check_val("relock errcnt", line_err_count, 1);

      // Frame 8 one line short, frame 9 clean
      drive_frame(VT - 1);
      check_val("f8 locked", locked, 1);
      check_val("f8 frame_count", frame_count, 6);
      drive_frame(VT);
      check_val("short frame locked", locked, 0);
      check_val("short frame frame_count", frame_count, 7);
      check_val("short frame errcnt", line_err_count, 1);

      // 300 short lines after one vsync edge
      for (int i = 0; i < 100; i++)
         drive_line(HT - 1, 1'b0);
      check_val("bad lines 100 errcnt", line_err_count, 100);
      for (int i = 0; i < 200; i++)
         drive_line(HT - 1, 1'b0);
      check_val("bad lines sat errcnt", line_err_count, 255);
      check_val("bad lines frame_count", frame_count, 7);
      check_val("bad lines locked", locked, 0);

      drive_line(HT, 1'b1);
      drive_frame(VT);
      drive_frame(VT);
      check_val("f12 locked", locked, 1);
      check_val("f12 frame_count", frame_count, 9);

      // Reset in the middle of a visible row of frame 13
      for (int l = 0; l < 4; l++)
         drive_line(HT, 1'b0);
      for (int c = 0; c < 7; c++)
         drive_cycle(1'b0, 1'b0, pix(c));
      @(negedge clk);
      check_val("pre reset rx_valid", rx_valid, 1);
      #2;
      reset = 1'b0;
      #1;
      check_val("mid rst rx_valid", rx_valid, 0);
      check_val("mid rst rx_x", rx_x, 0);
      check_val("mid rst locked", locked, 0);
      check_val("mid rst errcnt", line_err_count, 0);
      check_val("mid rst frame_count", frame_count, 0);
      for (int i = 0; i < 10; i++)
         drive_cycle(1'b0, 1'b0, 3'b101);
      reset = 1'b1;
      for (int l = 5; l < int'(VT); l++)
         drive_line(HT, l == int'(VT) - 1);
      drive_frame(VT);
      check_val("post rst f14 locked", locked, 0);
      drive_frame(VT);
      check_val("post rst f15 locked", locked, 1);
      check_val("post rst frame_count", frame_count, 1);
      check_val("post rst errcnt", line_err_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
